// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, ERROR} state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic pipe_hold;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN      = ctrl_t'(6'b110000);
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(6'b000001);
    localparam ctrl_t CTRL_RESET    = ctrl_t'(6'b001110);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(6'b111110);
    localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(6'b000100);
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from the pipeline and control fan-out back to it
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    import pipe_ctrl_pkg::*;
    logic [REG_IDX_W-1:0] id_rs;
    logic [REG_IDX_W-1:0] id_rt;
    logic                 id_uses_rt;
    logic                 idex_memRead;
    logic [REG_IDX_W-1:0] idex_rt;
    logic                 exmem_branch_taken;
    logic                 mem_busy;
    logic                 pc_write;
    logic                 ifid_write;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 exmem_flush;
    logic                 pipe_hold;
    logic                 err;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, idex_memRead, idex_rt, exmem_branch_taken, mem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_memRead, idex_rt, exmem_branch_taken, mem_busy,
        output pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, pipe_hold, err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is about to write
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic                 idex_memRead,
    input  logic [REG_IDX_W-1:0] idex_rt,
    output logic                 load_use
);
    assign load_use = idex_memRead && idex_rt != REG_ZERO &&
                      (idex_rt == id_rs || (id_uses_rt && idex_rt == id_rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / branch / mem-wait sequencer; HAZARD_PERF_EN adds stall and flush counters
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic                  clock,
    input logic                  reset_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic             load_use;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    ctrl_t            ctrl;

    load_use_detect u_lud (
        .id_rs        (hz.id_rs),
        .id_rt        (hz.id_rt),
        .id_uses_rt   (hz.id_uses_rt),
        .idex_memRead (hz.idex_memRead),
        .idex_rt      (hz.idex_rt),
        .load_use     (load_use)
    );

    // Next state and combinational controls; events ranked mem_busy > branch > load-use
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        ctrl    = CTRL_RUN;
        case (state_q)
            RUN, LU_STALL: begin
                if (hz.mem_busy) begin
                    ctrl    = CTRL_FREEZE;
                    state_d = MEM_WAIT;
                    tmo_d   = CNT_W'(1);
                end else if (hz.exmem_branch_taken) begin
                    ctrl    = CTRL_BRANCH;
                    state_d = RUN;
                end else if (load_use && state_q == RUN) begin
                    ctrl    = CTRL_LOAD_USE;
                    state_d = LU_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                ctrl = CTRL_FREEZE;
                if (!hz.mem_busy) begin
                    state_d = RUN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                ctrl  = CTRL_FREEZE;
                err_d = 1'b1;
            end
        endcase
        if (!reset_n) ctrl = CTRL_RESET;
    end

    // FSM, timeout counter and sticky error
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= RUN;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign hz.pc_write    = ctrl.pc_write;
    assign hz.ifid_write  = ctrl.ifid_write;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_flush = ctrl.exmem_flush;
    assign hz.pipe_hold   = ctrl.pipe_hold;
    assign hz.err         = err_q;

`ifdef HAZARD_PERF_EN
    logic             flush_ev;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    assign flush_ev = (state_q == RUN || state_q == LU_STALL) && !hz.mem_busy && hz.exmem_branch_taken;

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = (!ctrl.pc_write && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush_ev && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    // Counter registers cleared by reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard controls, timeout error, reset and counters
module tb_pipeline_hazard_ctrl;
    localparam logic [5:0] C_RUN    = 6'b110000;
    localparam logic [5:0] C_FREEZE = 6'b000001;
    localparam logic [5:0] C_RESET  = 6'b001110;
    localparam logic [5:0] C_BRANCH = 6'b111110;
    localparam logic [5:0] C_LU     = 6'b000100;

    logic clock = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(4)) hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz)
    );

    always #5 clock = ~clock;

    logic [5:0] ctrl_o;
    assign ctrl_o = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.pipe_hold};

    function automatic logic [3:0] cx(input logic [3:0] v);
`ifdef HAZARD_PERF_EN
        return v;
`else
        return 4'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic mr,
                         input logic [4:0] xrt, input logic br, input logic bz);
        hz.id_rs              = rs;
        hz.id_rt              = rt;
        hz.id_uses_rt         = ur;
        hz.idex_memRead       = mr;
        hz.idex_rt            = xrt;
        hz.exmem_branch_taken = br;
        hz.mem_busy           = bz;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("reset_ctrl", 32'(ctrl_o), 32'(C_RESET));
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("post_reset_ctrl", 32'(ctrl_o), 32'(C_RUN));
        check("post_reset_err", 32'(hz.err), 0);
        check("post_reset_stall", 32'(hz.stall_cnt), 0);
        check("post_reset_flush", 32'(hz.flush_cnt), 0);

        drive(5, 0, 1, 1, 5, 0, 0);
        check("lu_rs_stall", 32'(ctrl_o), 32'(C_LU));
        tick();
        check("lu_ignored_in_stall", 32'(ctrl_o), 32'(C_RUN));
        check("lu_stall_cnt", 32'(hz.stall_cnt), 32'(cx(1)));
        tick();

        drive(0, 0, 1, 1, 0, 0, 0);
        check("lu_r0_no_stall", 32'(ctrl_o), 32'(C_RUN));
        tick();
        drive(3, 5, 0, 1, 5, 0, 0);
        check("lu_rt_unused", 32'(ctrl_o), 32'(C_RUN));
        tick();
        drive(3, 5, 1, 1, 5, 0, 0);
        check("lu_rt_stall", 32'(ctrl_o), 32'(C_LU));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("lu_rt_release", 32'(ctrl_o), 32'(C_RUN));
        check("lu_rt_stall_cnt", 32'(hz.stall_cnt), 32'(cx(2)));
        tick();

        drive(5, 0, 1, 1, 5, 1, 0);
        check("br_over_lu", 32'(ctrl_o), 32'(C_BRANCH));
        tick();
        drive(5, 0, 1, 1, 5, 0, 0);
        check("br_stays_run", 32'(ctrl_o), 32'(C_LU));
        check("br_flush_cnt", 32'(hz.flush_cnt), 32'(cx(1)));
        tick();
        drive(5, 0, 1, 1, 5, 1, 0);
        check("br_in_lu_stall", 32'(ctrl_o), 32'(C_BRANCH));
        tick();
        check("br2_flush_cnt", 32'(hz.flush_cnt), 32'(cx(2)));
        check("br2_stall_cnt", 32'(hz.stall_cnt), 32'(cx(3)));

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 1);
            check($sformatf("busy_freeze_%0d", i), 32'(ctrl_o), 32'(C_FREEZE));
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        check("busy_release_freeze", 32'(ctrl_o), 32'(C_FREEZE));
        check("busy_release_err", 32'(hz.err), 0);
        tick();
        check("busy_then_branch", 32'(ctrl_o), 32'(C_BRANCH));
        tick();
        check("busy_stall_cnt", 32'(hz.stall_cnt), 32'(cx(7)));
        check("busy_flush_cnt", 32'(hz.flush_cnt), 32'(cx(3)));

        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            check($sformatf("tmo_ctrl_%0d", i), 32'(ctrl_o), 32'(C_FREEZE));
            check($sformatf("tmo_err_%0d", i), 32'(hz.err), (i == 5) ? 1 : 0);
            tick();
        end
        check("tmo_stall_cnt", 32'(hz.stall_cnt), 32'(cx(12)));
        for (int i = 0; i < 6; i++) begin
            drive(5, 0, 1, 1, 5, 1, 0);
            tick();
        end
        check("err_freeze", 32'(ctrl_o), 32'(C_FREEZE));
        check("err_sticky", 32'(hz.err), 1);
        check("stall_saturate", 32'(hz.stall_cnt), 32'(cx(15)));
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("err_reset_ctrl", 32'(ctrl_o), 32'(C_RESET));
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("err_cleared", 32'(hz.err), 0);
        check("err_reset_run", 32'(ctrl_o), 32'(C_RUN));
        check("err_reset_stall", 32'(hz.stall_cnt), 0);
        check("err_reset_flush", 32'(hz.flush_cnt), 0);

        drive(5, 0, 1, 1, 5, 0, 0);
        check("rst_lu_stall", 32'(ctrl_o), 32'(C_LU));
        tick();
        reset_n = 1'b0;
        drive(5, 0, 1, 1, 5, 0, 0);
        check("rst_in_lu_ctrl", 32'(ctrl_o), 32'(C_RESET));
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        check("rst_release_ctrl", 32'(ctrl_o), 32'(C_RUN));
        check("rst_release_stall", 32'(hz.stall_cnt), 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
